edge_frame_capture: RTL and testbench

//   Sink for the edge_detect output stream: after cap_start, captures one full
//   IMG_WIDTH x IMG_HEIGHT frame of in_valid-qualified pixels in raster order.

---
 rtl/edge_frame_capture.sv | 131 +++++++++++++
 tb/tb_edge_frame_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_frame_capture.sv
// rtl/edge_frame_capture.sv - captures one raster frame of qualified pixels into a frame buffer via a small FIFO
module edge_frame_capture #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_start,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  in_pix,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + PIX_W;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

    state_t             state;
    state_t             state_next;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [ADDR_W-1:0]  addr_cnt;
    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ENT_W-1:0]   last_entry;
    logic               fifo_empty;
    logic               fifo_full;
    logic               accept;
    logic               last_pix;
    logic               push;
    logic               pop;
    logic               start;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign accept     = in_valid && ((state == ARMED) || (state == CAPTURE));
    assign last_pix   = (row == ROW_W'(IMG_HEIGHT - 1)) && (col == COL_W'(IMG_WIDTH - 1));
    assign pop        = !fifo_empty && mem_ready;
    // A full FIFO still takes a pixel when the head leaves in the same cycle.
    assign push       = accept && (!fifo_full || pop);
    assign start      = (state == IDLE) && cap_start;

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (cap_start) state_next = ARMED;
            end
            ARMED:   if (in_valid) state_next = last_pix ? DRAIN : CAPTURE;
            CAPTURE: if (in_valid && last_pix) state_next = DRAIN;
            DRAIN: begin
                if (fifo_empty) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Dropped pixels still advance the counters so later addresses stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            addr_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                row      <= '0;
                col      <= '0;
                addr_cnt <= '0;
                overflow <= 1'b0;
            end else if (accept) begin
                addr_cnt <= addr_cnt + 1'b1;
                if (col == COL_W'(IMG_WIDTH - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (fifo_full && !pop) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_entry <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                last_entry <= fifo_mem[rd_ptr];
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {addr_cnt, in_pix};
    end

    // When empty, the port shows the last entry written rather than stale storage.
    assign mem_we = !fifo_empty;
    assign {mem_addr, mem_wdata} = fifo_empty ? last_entry : fifo_mem[rd_ptr];

endmodule

// File: tb/tb_edge_frame_capture.sv
// tb/tb_edge_frame_capture.sv - randomized bench with a queue-based reference model for edge_frame_capture
module tb_edge_frame_capture;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int N  = W * H;
    localparam int PW = 8;
    localparam int AW = 19;
    localparam int D  = 16;
    localparam int EW = AW + PW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cap_start;
    logic          in_valid;
    logic [PW-1:0] in_pix;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_ready;
    logic          busy;
    logic          done;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    edge_frame_capture #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW), .ADDR_W(AW), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cap_start(cap_start), .in_valid(in_valid),
        .in_pix(in_pix), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ready(mem_ready), .busy(busy), .done(done), .overflow(overflow)
    );

    // Model: phase 0 = idle, 1 = taking pixels, 2 = emptying the queue.
    logic [EW-1:0] mq[$];
    logic [EW-1:0] m_last = '0;
    int            m_phase = 0;
    int            m_idx = 0;
    bit            m_ovf = 1'b0;
    bit            m_pop, m_acc, m_fin, m_start;

    logic [EW-1:0] wlog[$];
    int            done_cnt = 0;
    logic [EW-1:0] exp_head;
    bit            exp_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_last  = '0;
            m_phase = 0;
            m_idx   = 0;
            m_ovf   = 1'b0;
        end else begin
            m_pop   = (mq.size() != 0) && mem_ready;
            m_acc   = (m_phase == 1) && in_valid;
            m_fin   = (m_phase == 2) && (mq.size() == 0);
            m_start = (m_phase == 0) && cap_start;
            if (m_pop) m_last = mq.pop_front();
            if (m_acc) begin
                if (mq.size() == D) m_ovf = 1'b1;
                else mq.push_back({AW'(m_idx), in_pix});
                m_idx++;
                if (m_idx == N) m_phase = 2;
            end
            if (m_fin) m_phase = 0;
            if (m_start) begin
                m_phase = 1;
                m_idx   = 0;
                m_ovf   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        exp_we   = (mq.size() != 0);
        exp_head = exp_we ? mq[0] : m_last;
        check("mem_we", mem_we, exp_we);
        check("mem_addr_wdata", {mem_addr, mem_wdata}, exp_head);
        check("busy", busy, m_phase != 0);
        check("done", done, (m_phase == 2) && (mq.size() == 0));
        check("overflow", overflow, m_ovf);
        if (mem_we && mem_ready) wlog.push_back({mem_addr, mem_wdata});
        if (done) done_cnt++;
    end

    task automatic start_cap();
        wlog.delete();
        done_cnt = 0;
        @(negedge clk);
        cap_start = 1'b1; in_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        cap_start = 1'b0;
    endtask

    // vmode: 0 always, 1 toggle, 2 random; rmode: 0 always, 2 mostly, 3 rarely; pmode: 0 ramp, 1 random
    task automatic run(input int vmode, input int rmode, input int pmode, input bit cs_mode, input string name);
        int cyc = 0;
        while (m_phase != 0 && cyc < 4000) begin
            @(negedge clk);
            in_valid  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            mem_ready = (rmode == 0) ? 1'b1 : (rmode == 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            in_pix    = (pmode == 0) ? PW'(16 + m_idx) : PW'($urandom);
            cap_start = cs_mode && (m_phase == 1) && ($urandom_range(0, 7) == 0);
            cyc++;
        end
        @(negedge clk);
        cap_start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        check({name, "_finished"}, m_phase == 0, 1);
    endtask

    initial begin
        int s0, errs, cyc;
        logic [EW-1:0] ent;
        rst_n = 1'b0; cap_start = 1'b0; in_valid = 1'b0; in_pix = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_mem_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_addr_data", {mem_addr, mem_wdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: streaming frame, no backpressure
        start_cap();
        run(0, 0, 0, 1'b0, "t1");
        check("t1_writes", wlog.size(), N);
        ent = wlog[0];
        check("t1_first", ent, {19'd0, 8'h10});
        ent = wlog[N-1];
        check("t1_last", ent, {19'd127, 8'h8f});
        check("t1_done_cnt", done_cnt, 1);
        check("t1_overflow", overflow, 0);

        // T2: bubbles every other cycle
        start_cap();
        run(1, 0, 0, 1'b0, "t2");
        errs = 0;
        foreach (wlog[k]) if (wlog[k] !== {AW'(k), PW'(16 + k)}) errs++;
        check("t2_writes", wlog.size(), N);
        check("t2_seq_errors", errs, 0);
        check("t2_done_cnt", done_cnt, 1);

        // T3: memory stalled for 20 pixels; pixels 16..19 dropped
        start_cap();
        repeat (20) begin
            @(negedge clk);
            in_valid = 1'b1; mem_ready = 1'b0; in_pix = PW'(16 + m_idx);
        end
        run(0, 0, 0, 1'b0, "t3");
        check("t3_overflow", overflow, 1);
        check("t3_writes", wlog.size(), N - 4);
        ent = wlog[15];
        check("t3_addr15", ent, {19'd15, 8'h1f});
        ent = wlog[16];
        check("t3_addr20", ent, {19'd20, 8'h24});
        check("t3_done_cnt", done_cnt, 1);

        // T4: fill to 16, then push and pop together on every cycle
        start_cap();
        repeat (16) begin
            @(negedge clk);
            in_valid = 1'b1; mem_ready = 1'b0; in_pix = PW'(16 + m_idx);
        end
        cyc = 0;
        while (m_idx < N && cyc < 1000) begin
            @(negedge clk);
            in_valid = 1'b1; mem_ready = 1'b1; in_pix = PW'(16 + m_idx);
            cyc++;
        end
        in_valid = 1'b0;
        s0 = wlog.size();
        run(0, 0, 0, 1'b0, "t4");
        check("t4_overflow", overflow, 0);
        check("t4_writes", wlog.size(), N);
        check("t4_drain_writes", wlog.size() - s0, 16);

        // T5: reset at pixel 100, then a fresh capture
        start_cap();
        cyc = 0;
        while (m_idx < 100 && cyc < 1000) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0); mem_ready = ($urandom_range(0, 3) != 0);
            in_pix = PW'($urandom);
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        #1;
        check("t5_rst_mem_we", mem_we, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_overflow", overflow, 0);
        check("t5_rst_addr_data", {mem_addr, mem_wdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_cap();
        run(2, 2, 1, 1'b0, "t5");
        ent = (wlog.size() > 0) ? wlog[0] : '1;
        check("t5_first_addr", ent[EW-1:PW], 0);
        check("t5_done_cnt", done_cnt, 1);

        // T6: cap_start pulses during capture are ignored
        start_cap();
        run(2, 2, 1, 1'b1, "t6");
        errs = 0;
        for (int k = 1; k < wlog.size(); k++) if (wlog[k][EW-1:PW] <= wlog[k-1][EW-1:PW]) errs++;
        check("t6_addr_order", errs, 0);
        check("t6_done_cnt", done_cnt, 1);

        // Randomized frames, including heavy backpressure
        for (int f = 0; f < 4; f++) begin
            start_cap();
            run(2, (f % 2 == 0) ? 2 : 3, 1, 1'b1, "rand");
            check("rand_done_cnt", done_cnt, 1);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
